seg7_frame_decoder: RTL and testbench
=====================================

# seg7_frame_decoder

Reader-side companion to the HELLO rotating display path. It accepts one frame of five active-low 7-segment digit patterns from a scanned segment bus, one digit per strobe from HEX4 down to HEX0. Each pattern is decoded back to its 3-bit character code, and the five codes are assembled into a 15-bit frame. The block then reports which HELLO rotation the frame matches and hands the frame out over a valid/ready handshake. It sits between a display-bus monitor and self-check or logging logic.

## Interface
Parameters:
- DIGITS, 5: digits per frame. Fixed at 5; other values are not supported.

Ports:
- CLOCK_50  in  1  system clock. Every register is clocked on its rising edge.
- Resetn  in  1  reset, asynchronous and active-low.
- seg_in  in  7  segment pattern {g,f,e,d,c,b,a}. A 0 means the segment is lit.
- digit_sel  in  3  index of the presented digit. 4 is HEX4 (leftmost); 0 is HEX0.
- seg_valid  in  1  digit strobe. seg_in and digit_sel are sampled when it is 1.
- frame_start  in  1  qualifies a strobe as the first digit of a frame.
- char_out  out  15  frame codes {C4,C3,C2,C1,C0}.
- rot  out  3  matched rotation, 0..4. The value 7 means no match.
- frame_valid  out  1  char_out and rot are valid.
- out_ready  in  1  consumer accepts the frame.
- illegal  out  1  one-cycle pulse when a pattern outside the character set is decoded.
- seq_err  out  1  one-cycle pulse when a frame is dropped for a sequence violation.
- overrun  out  1  sticky flag. It is cleared only by reset.

## Operation
Pattern decode, seg_in to code:
- 0001001 → 000 (H).
- 0000110 → 001 (E).
- 1000111 → 010 (L).
- 1000000 → 011 (O).
- 1111111 → 100 (blank).
- Any other pattern → 111, and illegal pulses. The frame is still collected.

Collector FSM, states IDLE and COLLECT, with an expected-index register exp:
- IDLE: waits for a strobe with frame_start=1 and digit_sel=4. That strobe stores C4, sets exp=3 and moves to COLLECT. Any other strobe is ignored.
- COLLECT, strobe with digit_sel==exp and frame_start=0: stores the code and decrements exp. When digit 0 is stored, the frame is complete and the FSM returns to IDLE.
- COLLECT, strobe with digit_sel≠exp: seq_err pulses, the partial frame is dropped, and the FSM returns to IDLE.
- COLLECT, strobe with frame_start=1 and digit_sel=4: restarts collection at C4. No error is flagged.
- COLLECT, strobe with frame_start=1 and digit_sel≠4: treated as a sequence error.

Output register:
- On frame completion, if frame_valid=0 or out_ready=1 in the same cycle, char_out and rot load and frame_valid is 1 on the next cycle.
- Otherwise the completed frame is discarded, overrun is set, and the held frame is kept unchanged.
- frame_valid clears after any cycle with frame_valid=1 and out_ready=1, unless a new frame loads in that same cycle.
- While frame_valid=1, char_out and rot are stable.

Rotation detection, with the canonical word H,E,L,L,O:
- rot=r when C4..C0 equal HELLO rotated left by r. Examples: rot=1 is ELLOH; rot=4 is OHELL.
- Any other frame gives rot=7. This includes frames containing blank or illegal codes.

## Timing
- Reset values: char_out=0, rot=7, frame_valid=0, illegal=0, seq_err=0, overrun=0. The FSM resets to IDLE with exp=4.
- Latency: frame_valid rises 1 cycle after the strobe that carried digit 0.
- illegal and seq_err pulse in the cycle after the offending strobe.
- Strobes may arrive back-to-back, one per cycle. Full throughput is one frame per 5 cycles when out_ready is held at 1.
- Reset asserted mid-frame discards the partial frame and any held output. Operation resumes in IDLE on the first edge after release.

## Configuration
- SEG7_DEC_ROT_EN defined: the rotation comparator is built and rot is updated as described above.
- SEG7_DEC_ROT_EN undefined: there is no comparator logic and rot is a constant 3'b111. All other behaviour is unchanged.

## Structure
Shared package seg7_pkg holds:
- The 3-bit character codes: CH_H, CH_E, CH_L, CH_O, CH_BLANK, CH_BAD.
- The five 7-bit segment constants.
- The canonical HELLO word, as a 15-bit constant.
- The FSM state enum.

One sub-module, seg7_to_char, is purely combinational. It maps 7 bits to a 3-bit code plus a bad flag, and is instantiated once on seg_in.

## Test plan
- HELLO frame: strobes digit 4..0 with patterns 0001001, 0000110, 1000111, 1000111, 1000000, out_ready=1. Required: char_out=15'o01223 ({000,001,010,010,011}), rot=0, frame_valid high for 1 cycle, one cycle after the last strobe.
- Rotation sweep: the frames ELLOH, LLOHE, LOHEL and OHELL give rot=1,2,3,4. The frame HHHHH gives rot=7.
- Illegal pattern: 0101010 presented on digit 2. Required: illegal pulses, C2=111, the frame completes, and rot=7.
- Sequence error: digits 4,3 then digit_sel=1. Required: seq_err pulses and there is no frame_valid. A fresh HELLO frame afterwards decodes normally.
- Backpressure: out_ready=0 while two frames complete. Required: the first frame is held, overrun=1, and the second frame is lost. Then out_ready=1 for 1 cycle: frame_valid drops and overrun stays 1.
- Reset mid-frame: Resetn pulsed low after digit 2. Required: all outputs return to their reset values, and the next full frame decodes correctly.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment frame reader: character codes, segment
// patterns, the canonical HELLO word and the collector state encoding.
package seg7_pkg;

   localparam logic [2:0] CH_H     = 3'd0;
   localparam logic [2:0] CH_E     = 3'd1;
   localparam logic [2:0] CH_L     = 3'd2;
   localparam logic [2:0] CH_O     = 3'd3;
   localparam logic [2:0] CH_BLANK = 3'd4;
   localparam logic [2:0] CH_BAD   = 3'd7;

   // Active-low patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_H     = 7'b0001001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_L     = 7'b1000111;
   localparam logic [6:0] SEG_O     = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [14:0] HELLO_WORD = {CH_H, CH_E, CH_L, CH_L, CH_O};

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } state_e;

   // Rotate a five-character word left by r character positions (r in 0..4).
   function automatic logic [14:0] rotl_word(input logic [14:0] w, input int r);
      logic [14:0] t;
      t = w;
      for (int i = 0; i < 4; i++) begin
         if (i < r) t = {t[11:0], t[14:12]};
      end
      return t;
   endfunction

endpackage

// File: rtl/seg7_to_char.sv
// Combinational decode of one active-low 7-segment pattern to its character
// code; unknown patterns yield CH_BAD with bad_o set.
module seg7_to_char
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [2:0] code_o,
   output logic       bad_o
);

   always_comb begin
      code_o = CH_BAD;
      bad_o  = 1'b0;
      case (seg_i)
         SEG_H:     code_o = CH_H;
         SEG_E:     code_o = CH_E;
         SEG_L:     code_o = CH_L;
         SEG_O:     code_o = CH_O;
         SEG_BLANK: code_o = CH_BLANK;
         default:   bad_o  = 1'b1;
      endcase
   end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Collects five scanned 7-segment digits (HEX4..HEX0) into a 15-bit frame and
// hands it out over valid/ready. Define SEG7_DEC_ROT_EN to build the HELLO
// rotation comparator; otherwise rot is tied to 3'b111.
module seg7_frame_decoder
   import seg7_pkg::*;
#(
   parameter int DIGITS = 5
) (
   input  logic        CLOCK_50,
   input  logic        Resetn,
   input  logic [6:0]  seg_in,
   input  logic [2:0]  digit_sel,
   input  logic        seg_valid,
   input  logic        frame_start,
   output logic [14:0] char_out,
   output logic [2:0]  rot,
   output logic        frame_valid,
   input  logic        out_ready,
   output logic        illegal,
   output logic        seq_err,
   output logic        overrun
);

   localparam logic [2:0] TOP_IDX = 3'(DIGITS - 1);

   logic [2:0]       code;
   logic             bad;
   state_e           state_q, state_d;
   logic [2:0]       exp_q, exp_d;
   logic [4:0][2:0]  frame_q, frame_d;
   logic [14:0]      char_q, char_d;
   logic             fv_q, fv_d;
   logic             illegal_q, illegal_d;
   logic             seq_err_q, seq_err_d;
   logic             overrun_q, overrun_d;
   logic             start_hit;
   logic             complete;
   logic             load;

   seg7_to_char u_dec (
      .seg_i  (seg_in),
      .code_o (code),
      .bad_o  (bad)
   );

   assign start_hit = seg_valid && frame_start && (digit_sel == TOP_IDX);

   always_comb begin
      state_d   = state_q;
      exp_d     = exp_q;
      frame_d   = frame_q;
      complete  = 1'b0;
      seq_err_d = 1'b0;
      illegal_d = seg_valid && bad;
      if (start_hit) begin
         // A qualified HEX4 strobe (re)starts a frame from any state.
         frame_d[TOP_IDX] = code;
         exp_d            = TOP_IDX - 3'd1;
         state_d          = ST_COLLECT;
      end else if (seg_valid && state_q == ST_COLLECT) begin
         if (!frame_start && digit_sel == exp_q) begin
            frame_d[exp_q] = code;
            if (exp_q == 3'd0) begin
               complete = 1'b1;
               state_d  = ST_IDLE;
               exp_d    = TOP_IDX;
            end else begin
               exp_d = exp_q - 3'd1;
            end
         end else begin
            seq_err_d = 1'b1;
            state_d   = ST_IDLE;
            exp_d     = TOP_IDX;
         end
      end
   end

   always_comb begin
      load      = complete && (!fv_q || out_ready);
      char_d    = char_q;
      fv_d      = fv_q;
      overrun_d = overrun_q;
      if (load) begin
         char_d = frame_d;
         fv_d   = 1'b1;
      end else begin
         if (complete) overrun_d = 1'b1;
         if (fv_q && out_ready) fv_d = 1'b0;
      end
   end

`ifdef SEG7_DEC_ROT_EN
   logic [2:0] rot_q, rot_d, rot_calc;

   always_comb begin
      rot_calc = 3'b111;
      for (int r = 0; r < DIGITS; r++) begin
         if (frame_d == rotl_word(HELLO_WORD, r)) rot_calc = 3'(r);
      end
      rot_d = load ? rot_calc : rot_q;
   end

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) rot_q <= 3'b111;
      else         rot_q <= rot_d;
   end

   assign rot = rot_q;
`else
   assign rot = 3'b111;
`endif

   always_ff @(posedge CLOCK_50 or negedge Resetn) begin
      if (!Resetn) begin
         state_q   <= ST_IDLE;
         exp_q     <= TOP_IDX;
         frame_q   <= '0;
         char_q    <= '0;
         fv_q      <= 1'b0;
         illegal_q <= 1'b0;
         seq_err_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         exp_q     <= exp_d;
         frame_q   <= frame_d;
         char_q    <= char_d;
         fv_q      <= fv_d;
         illegal_q <= illegal_d;
         seq_err_q <= seq_err_d;
         overrun_q <= overrun_d;
      end
   end

   assign char_out    = char_q;
   assign frame_valid = fv_q;
   assign illegal     = illegal_q;
   assign seq_err     = seq_err_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Directed bench for seg7_frame_decoder: a frame-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_seg7_frame_decoder;

`ifdef SEG7_DEC_ROT_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   localparam logic [6:0] P_H = 7'b0001001;
   localparam logic [6:0] P_E = 7'b0000110;
   localparam logic [6:0] P_L = 7'b1000111;
   localparam logic [6:0] P_O = 7'b1000000;
   localparam logic [6:0] P_X = 7'b0101010;

   logic        CLOCK_50 = 1'b0;
   logic        Resetn = 1'b1;
   logic [6:0]  seg_in = 7'h7f;
   logic [2:0]  digit_sel = 3'd0;
   logic        seg_valid = 1'b0;
   logic        frame_start = 1'b0;
   logic        out_ready = 1'b1;
   logic [14:0] char_out;
   logic [2:0]  rot;
   logic        frame_valid;
   logic        illegal;
   logic        seq_err;
   logic        overrun;

   int total = 0;
   int bad = 0;

   seg7_frame_decoder #(.DIGITS(5)) dut (
      .CLOCK_50    (CLOCK_50),
      .Resetn      (Resetn),
      .seg_in      (seg_in),
      .digit_sel   (digit_sel),
      .seg_valid   (seg_valid),
      .frame_start (frame_start),
      .char_out    (char_out),
      .rot         (rot),
      .frame_valid (frame_valid),
      .out_ready   (out_ready),
      .illegal     (illegal),
      .seq_err     (seq_err),
      .overrun     (overrun)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // ---------------- reference model ----------------
   // Character set in code order: H=0, E=1, L=2, O=3, blank=4.
   logic [6:0] pat_tab [5] = '{7'b0001001, 7'b0000110, 7'b1000111, 7'b1000000, 7'b1111111};
   int         hello [5] = '{0, 1, 2, 2, 3};

   bit          m_active = 1'b0;
   int          m_cnt = 0;
   logic [2:0]  m_codes [5] = '{default: 3'd0};
   logic [14:0] m_char = '0;
   logic [2:0]  m_rot = 3'd7;
   bit          m_fv = 1'b0, m_ill = 1'b0, m_seq = 1'b0, m_ovr = 1'b0;

   function automatic logic [3:0] tb_decode(input logic [6:0] s);
      for (int i = 0; i < 5; i++) if (s == pat_tab[i]) return {1'b0, 3'(i)};
      return {1'b1, 3'd7};
   endfunction

   function automatic logic [2:0] tb_rot(input logic [14:0] w);
      bit ok;
      if (!ROT_EN) return 3'd7;
      for (int r = 0; r < 5; r++) begin
         ok = 1'b1;
         for (int k = 0; k < 5; k++)
            if (int'(w[14 - 3*k -: 3]) != hello[(k + r) % 5]) ok = 1'b0;
         if (ok) return 3'(r);
      end
      return 3'd7;
   endfunction

   always @(posedge CLOCK_50 or negedge Resetn) begin
      logic [3:0]  d;
      logic [14:0] w;
      bit          fire;
      if (!Resetn) begin
         m_active = 1'b0; m_cnt = 0; m_char = '0; m_rot = 3'd7;
         m_fv = 1'b0; m_ill = 1'b0; m_seq = 1'b0; m_ovr = 1'b0;
      end else begin
         d = tb_decode(seg_in);
         fire = 1'b0;
         m_ill = seg_valid && d[3];
         m_seq = 1'b0;
         if (seg_valid) begin
            if (frame_start && digit_sel == 3'd4) begin
               m_active = 1'b1; m_codes[4] = d[2:0]; m_cnt = 1;
            end else if (m_active) begin
               if (!frame_start && int'(digit_sel) == 4 - m_cnt) begin
                  m_codes[digit_sel] = d[2:0];
                  m_cnt++;
                  if (m_cnt == 5) begin fire = 1'b1; m_active = 1'b0; end
               end else begin
                  m_seq = 1'b1; m_active = 1'b0;
               end
            end
         end
         if (fire) begin
            w = {m_codes[4], m_codes[3], m_codes[2], m_codes[1], m_codes[0]};
            if (!m_fv || out_ready) begin
               m_char = w; m_rot = tb_rot(w); m_fv = 1'b1;
            end else begin
               m_ovr = 1'b1;
            end
         end else if (m_fv && out_ready) begin
            m_fv = 1'b0;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %o expected %o at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_loop();
      forever begin
         @(negedge CLOCK_50);
         check("cyc_char", char_out, m_char);
         check("cyc_rot", 15'(rot), 15'(m_rot));
         check("cyc_fv", 15'(frame_valid), 15'(m_fv));
         check("cyc_illegal", 15'(illegal), 15'(m_ill));
         check("cyc_seq_err", 15'(seq_err), 15'(m_seq));
         check("cyc_overrun", 15'(overrun), 15'(m_ovr));
      end
   endtask

   // One clock of stimulus; returns 2 time units after the sampling edge.
   task automatic cyc(input bit v, input bit fs, input logic [2:0] sel, input logic [6:0] seg);
      seg_valid = v; frame_start = fs; digit_sel = sel; seg_in = seg;
      @(posedge CLOCK_50);
      #2;
      seg_valid = 1'b0; frame_start = 1'b0;
   endtask

   task automatic send_frame(input logic [6:0] p4, p3, p2, p1, p0);
      cyc(1, 1, 3'd4, p4);
      cyc(1, 0, 3'd3, p3);
      cyc(1, 0, 3'd2, p2);
      cyc(1, 0, 3'd1, p1);
      cyc(1, 0, 3'd0, p0);
   endtask

   task automatic pin_reset(input string tag);
      check({tag, "_char"}, char_out, 15'o0);
      check({tag, "_rot"}, 15'(rot), 15'd7);
      check({tag, "_fv"}, 15'(frame_valid), 15'd0);
      check({tag, "_ovr"}, 15'(overrun), 15'd0);
   endtask

   task automatic pin_frame(input string tag, input logic [14:0] c, input int r);
      check({tag, "_char"}, char_out, c);
      check({tag, "_rot"}, 15'(rot), ROT_EN ? 15'(r) : 15'd7);
      check({tag, "_fv"}, 15'(frame_valid), 15'd1);
   endtask

   initial begin
      fork
         compare_loop();
      join_none
      #1 Resetn = 1'b0;
      repeat (3) @(posedge CLOCK_50);
      #2;
      pin_reset("rst");
      Resetn = 1'b1;
      cyc(0, 0, 3'd0, 7'h7f);

      // HELLO frame, ready held high
      send_frame(P_H, P_E, P_L, P_L, P_O);
      pin_frame("hello", 15'o01223, 0);
      cyc(0, 0, 3'd0, 7'h7f);
      check("hello_fv_drop", 15'(frame_valid), 15'd0);

      // Rotation sweep, back-to-back frames
      send_frame(P_E, P_L, P_L, P_O, P_H);
      pin_frame("ellohh", 15'o12230, 1);
      send_frame(P_L, P_L, P_O, P_H, P_E);
      pin_frame("llohe", 15'o22301, 2);
      send_frame(P_L, P_O, P_H, P_E, P_L);
      pin_frame("lohel", 15'o23012, 3);
      send_frame(P_O, P_H, P_E, P_L, P_L);
      pin_frame("ohell", 15'o30122, 4);
      send_frame(P_H, P_H, P_H, P_H, P_H);
      pin_frame("hhhhh", 15'o00000, 7);
      cyc(0, 0, 3'd0, 7'h7f);

      // Illegal pattern on digit 2
      cyc(1, 1, 3'd4, P_H);
      cyc(1, 0, 3'd3, P_E);
      cyc(1, 0, 3'd2, P_X);
      check("illegal_pulse", 15'(illegal), 15'd1);
      cyc(1, 0, 3'd1, P_L);
      check("illegal_clear", 15'(illegal), 15'd0);
      cyc(1, 0, 3'd0, P_O);
      pin_frame("illegal", 15'o01723, 7);
      cyc(0, 0, 3'd0, 7'h7f);

      // Sequence error: 4, 3, then 1
      cyc(1, 1, 3'd4, P_H);
      cyc(1, 0, 3'd3, P_E);
      cyc(1, 0, 3'd1, P_L);
      check("seq_pulse", 15'(seq_err), 15'd1);
      cyc(1, 0, 3'd0, P_O);
      check("seq_no_fv", 15'(frame_valid), 15'd0);
      send_frame(P_H, P_E, P_L, P_L, P_O);
      pin_frame("after_seq", 15'o01223, 0);
      cyc(0, 0, 3'd0, 7'h7f);

      // Backpressure: two frames complete while out_ready=0
      out_ready = 1'b0;
      send_frame(P_H, P_E, P_L, P_L, P_O);
      pin_frame("bp_first", 15'o01223, 0);
      send_frame(P_E, P_L, P_L, P_O, P_H);
      pin_frame("bp_held", 15'o01223, 0);
      check("bp_overrun", 15'(overrun), 15'd1);
      out_ready = 1'b1;
      cyc(0, 0, 3'd0, 7'h7f);
      check("bp_fv_drop", 15'(frame_valid), 15'd0);
      check("bp_overrun_sticky", 15'(overrun), 15'd1);

      // Reset after digit 2 of a frame
      cyc(1, 1, 3'd4, P_O);
      cyc(1, 0, 3'd3, P_H);
      cyc(1, 0, 3'd2, P_E);
      Resetn = 1'b0;
      @(posedge CLOCK_50);
      #2;
      pin_reset("midrst");
      Resetn = 1'b1;
      cyc(1, 0, 3'd1, P_L);
      cyc(1, 0, 3'd0, P_L);
      check("midrst_no_fv", 15'(frame_valid), 15'd0);
      send_frame(P_O, P_H, P_E, P_L, P_L);
      pin_frame("after_rst", 15'o30122, 4);
      repeat (3) cyc(0, 0, 3'd0, 7'h7f);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
